hub75_scan_ctrl: RTL and testbench
==================================

HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 SHALL have parameter HPIXEL_P, default 64: display width in pixels.
REQ-002 SHALL have parameter VPIXEL_P, default 64: display height in pixels.
REQ-003 SHALL have parameter BPP_P, default 8: bits per colour channel, equal to the number of bit-planes.
REQ-004 SHALL have parameter SEGMENTS_P, default 2: panel segments driven in parallel; ROWS = VPIXEL_P/SEGMENTS_P.
REQ-005 SHALL have parameter CLK_DIV_P, default 2 (min 1): clk cycles per half period of o_hub_clk.
REQ-006 SHALL have parameter LSB_OE_CYCLES_P, default 8: OE-low cycles for bit-plane 0.
REQ-007 SHALL have parameter BLANK_CYCLES_P, default 4: settle cycles, used only under HUB75_ROW_BLANK_EN.
REQ-008 SHALL have port clk, input, 1: clock.
REQ-009 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-010 SHALL have port i_en, input, 1: scanning enable.
REQ-011 SHALL have port o_rd_addr, output, clog2(HPIXEL_P*VPIXEL_P): pixel read address, row*HPIXEL_P+col.
REQ-012 SHALL have port i_rd_data, input, SEGMENTS_P x 3 x BPP_P: RGB per segment, valid exactly 1 cycle after o_rd_addr.
REQ-013 SHALL have port o_hub_clk, output, 1: panel shift clock.
REQ-014 SHALL have port o_hub_lat, output, 1: panel latch.
REQ-015 SHALL have port o_hub_oe_n, output, 1: panel output enable, active-low.
REQ-016 SHALL have port o_hub_addr, output, clog2(ROWS): panel row address.
REQ-017 SHALL have port o_hub_rgb, output, SEGMENTS_P x 3: shift data, R,G,B per segment.
REQ-018 SHALL have port o_frame_start, output, 1: one-cycle pulse at the start of each frame.

Function
REQ-019 SHALL implement states IDLE, FETCH, SHIFT, LATCH, [BLANK], DISPLAY; all outputs registered.
REQ-020 IDLE: oe_n=1, clk=0, lat=0; when i_en=1, SHALL go to FETCH with row=0, plane=0, and pulse o_frame_start on that cycle.
REQ-021 FETCH SHALL last 2 cycles: o_rd_addr=row*HPIXEL_P+0, then capture i_rd_data into the pending register.
REQ-022 SHIFT SHALL last HPIXEL_P pixel slots of 2*CLK_DIV_P cycles each, with phase p=0..2*CLK_DIV_P-1.
REQ-023 In SHIFT, at p=0 of slot c, o_hub_rgb[s][k] SHALL take the pending bit i_rd_data[s][k][plane] and o_rd_addr SHALL equal the address of column c+1.
REQ-024 In SHIFT, data SHALL be captured into pending at p=1, except in the last slot, which SHALL issue no fetch.
REQ-025 o_hub_clk SHALL be 0 for p<CLK_DIV_P and 1 otherwise; o_hub_rgb SHALL change only at p=0; o_hub_oe_n=1 throughout SHIFT.
REQ-026 LATCH SHALL last CLK_DIV_P cycles with o_hub_lat=1, o_hub_clk=0, oe_n=1; o_hub_addr SHALL be loaded with row on LATCH entry.
REQ-027 DISPLAY SHALL hold o_hub_oe_n=0 for exactly LSB_OE_CYCLES_P<<plane cycles, counted by a BCM timer.
REQ-028 At the end of DISPLAY, if plane<BPP_P-1: plane+1, then FETCH.
REQ-029 At the end of DISPLAY, if plane=BPP_P-1: plane=0 and row+1, wrapping ROWS-1 to 0; the wrap SHALL pulse o_frame_start on FETCH entry.
REQ-030 i_en SHALL be sampled only at the end of DISPLAY and in IDLE; if i_en=0 at the end of DISPLAY, SHALL go to IDLE, and the next start SHALL restart at row 0, plane 0.
REQ-031 Counters SHALL be sized for their maximum value; the OE count LSB_OE_CYCLES_P<<(BPP_P-1) SHALL not overflow.

Reset
REQ-032 While rst_n=0 at a clk edge, the block SHALL enter IDLE, including mid-SHIFT or mid-DISPLAY.
REQ-033 Reset values: o_rd_addr=0, o_hub_clk=0, o_hub_lat=0, o_hub_oe_n=1, o_hub_addr=0, o_hub_rgb=0, o_frame_start=0, row=plane=0.

Configuration
REQ-034 With HUB75_ROW_BLANK_EN defined, LATCH SHALL go to BLANK, which holds oe_n=1, lat=0 for BLANK_CYCLES_P cycles, then goes to DISPLAY.
REQ-035 Without HUB75_ROW_BLANK_EN, LATCH SHALL go directly to DISPLAY, the BLANK state SHALL be absent and BLANK_CYCLES_P ignored.

Structure
REQ-036 Package hub75_pkg SHALL hold the scan state enum, a per-segment RGB pixel typedef and the default timing constants.
REQ-037 Sub-module hub75_bcm_timer SHALL provide a load-with-(LSB_OE_CYCLES_P<<plane) down-counter and a done flag used by DISPLAY.

Verification
Bench configuration: HPIXEL_P=8, VPIXEL_P=4, SEGMENTS_P=2, BPP_P=2, CLK_DIV_P=1, LSB_OE_CYCLES_P=4, no blank.
REQ-038 i_en=1 from reset -> o_frame_start first pulses one cycle after i_en is seen, then every 100 cycles (plane0 23 + plane1 27 cycles, x2 rows).
REQ-039 Test-bar pixel source attached -> 8 o_hub_clk rises per plane, with o_hub_rgb matching bit plane of column colour per rise; lat pulses once per plane.
REQ-040 Run one frame -> oe_n low runs are 4, 8, 4, 8 cycles; o_hub_addr 0, 0, 1, 1; never low while o_hub_clk toggles.
REQ-041 i_en dropped mid-SHIFT of row 1 -> completes that plane's DISPLAY, enters IDLE with oe_n=1; re-enable -> restarts at row 0, o_hub_addr=0 at next LATCH.
REQ-042 rst_n=0 for 1 cycle mid-DISPLAY -> next cycle all outputs at reset values, IDLE.
REQ-043 HUB75_ROW_BLANK_EN with BLANK_CYCLES_P=3 -> exactly 3 cycles of oe_n=1 between lat falling and oe_n falling; frame period 112 cycles.

Source files
------------

// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - HUB75 scan types and default timing; ST_BLANK exists only under HUB75_ROW_BLANK_EN
package hub75_pkg;

    localparam int DEF_HPIXEL        = 64;
    localparam int DEF_VPIXEL        = 64;
    localparam int DEF_BPP           = 8;
    localparam int DEF_SEGMENTS      = 2;
    localparam int DEF_CLK_DIV       = 2;
    localparam int DEF_LSB_OE_CYCLES = 8;
    localparam int DEF_BLANK_CYCLES  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_LATCH   = 3'd3,
`ifdef HUB75_ROW_BLANK_EN
        ST_BLANK   = 3'd4,
`endif
        ST_DISPLAY = 3'd5
    } scan_state_e;

    // One segment's pixel at the default depth; B occupies the low bits of a read word.
    typedef struct packed {
        logic [DEF_BPP-1:0] r;
        logic [DEF_BPP-1:0] g;
        logic [DEF_BPP-1:0] b;
    } rgb_pixel_t;

    // Bit position of plane b of channel k (0=B, 1=G, 2=R) of segment s in a read word.
    function automatic int rgb_bit_idx(input int s, input int k, input int b, input int bpp);
        return (s * 3 + k) * bpp + b;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// rtl/hub75_bcm_timer.sv - binary-coded-modulation OE down-counter, loaded with LSB_OE_CYCLES_P << plane
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int LSB_OE_CYCLES_P = DEF_LSB_OE_CYCLES,
    parameter int BPP_P           = DEF_BPP,
    parameter int PLANE_W_P       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [PLANE_W_P-1:0] plane_i,
    output logic                 done_o
);
    localparam int MAX_CNT = LSB_OE_CYCLES_P << (BPP_P - 1);
    localparam int TW      = $clog2(MAX_CNT + 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= TW'(LSB_OE_CYCLES_P) << plane_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    // Asserted during the last cycle of the loaded count.
    assign done_o = (cnt_q == TW'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - HUB75 row/bit-plane scan FSM; optional BLANK settle state under HUB75_ROW_BLANK_EN
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int HPIXEL_P        = DEF_HPIXEL,
    parameter int VPIXEL_P        = DEF_VPIXEL,
    parameter int BPP_P           = DEF_BPP,
    parameter int SEGMENTS_P      = DEF_SEGMENTS,
    parameter int CLK_DIV_P       = DEF_CLK_DIV,
    parameter int LSB_OE_CYCLES_P = DEF_LSB_OE_CYCLES,
    parameter int BLANK_CYCLES_P  = DEF_BLANK_CYCLES
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     i_en,
    output logic [$clog2(HPIXEL_P*VPIXEL_P)-1:0]     o_rd_addr,
    input  logic [SEGMENTS_P*3*BPP_P-1:0]            i_rd_data,
    output logic                                     o_hub_clk,
    output logic                                     o_hub_lat,
    output logic                                     o_hub_oe_n,
    output logic [$clog2(VPIXEL_P/SEGMENTS_P)-1:0]   o_hub_addr,
    output logic [SEGMENTS_P*3-1:0]                  o_hub_rgb,
    output logic                                     o_frame_start
);
    localparam int ROWS    = VPIXEL_P / SEGMENTS_P;
    localparam int AW      = $clog2(HPIXEL_P * VPIXEL_P);
    localparam int RW      = $clog2(ROWS);
    localparam int CW      = (HPIXEL_P > 1) ? $clog2(HPIXEL_P) : 1;
    localparam int PW      = (BPP_P > 1) ? $clog2(BPP_P) : 1;
    localparam int DW      = SEGMENTS_P * 3 * BPP_P;
    localparam int SUB_MAX = (2 * CLK_DIV_P > BLANK_CYCLES_P) ? 2 * CLK_DIV_P : BLANK_CYCLES_P;
    localparam int SW      = $clog2(SUB_MAX);

    scan_state_e        state_q;
    logic [SW-1:0]      sub_q;
    logic [CW-1:0]      col_q;
    logic [RW-1:0]      row_q;
    logic [PW-1:0]      plane_q;
    logic [DW-1:0]      pend_q, pend_d;
    logic [AW-1:0]      rd_addr_q;
    logic               hub_clk_q, lat_q, oe_n_q, fs_q;
    logic [RW-1:0]      hub_addr_q;
    logic [SEGMENTS_P*3-1:0] rgb_q, rgb_d;
    logic               capture, tmr_load, tmr_done;

    function automatic logic [AW-1:0] row_base(input logic [RW-1:0] r);
        return AW'(r) * AW'(HPIXEL_P);
    endfunction

    // Pixel data arrives one cycle after its address; capture on the cycle it is valid.
    assign capture = (state_q == ST_FETCH && sub_q == SW'(1)) ||
                     (state_q == ST_SHIFT && sub_q == SW'(1) && col_q != CW'(HPIXEL_P - 1));
    assign pend_d  = capture ? i_rd_data : pend_q;

    always_comb begin
        rgb_d = '0;
        for (int s = 0; s < SEGMENTS_P; s++) begin
            for (int k = 0; k < 3; k++) begin
                rgb_d[s*3+k] = 1'(pend_d >> rgb_bit_idx(s, k, int'(plane_q), BPP_P));
            end
        end
    end

`ifdef HUB75_ROW_BLANK_EN
    assign tmr_load = (state_q == ST_BLANK) && (sub_q == SW'(BLANK_CYCLES_P - 1));
`else
    assign tmr_load = (state_q == ST_LATCH) && (sub_q == SW'(CLK_DIV_P - 1));
`endif

    hub75_bcm_timer #(
        .LSB_OE_CYCLES_P (LSB_OE_CYCLES_P),
        .BPP_P           (BPP_P),
        .PLANE_W_P       (PW)
    ) u_bcm_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .plane_i (plane_q),
        .done_o  (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sub_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            plane_q    <= '0;
            pend_q     <= '0;
            rd_addr_q  <= '0;
            hub_clk_q  <= 1'b0;
            lat_q      <= 1'b0;
            oe_n_q     <= 1'b1;
            hub_addr_q <= '0;
            rgb_q      <= '0;
            fs_q       <= 1'b0;
        end else begin
            fs_q   <= 1'b0;
            pend_q <= pend_d;
            case (state_q)
                ST_IDLE: begin
                    oe_n_q    <= 1'b1;
                    hub_clk_q <= 1'b0;
                    lat_q     <= 1'b0;
                    if (i_en) begin
                        state_q   <= ST_FETCH;
                        sub_q     <= '0;
                        row_q     <= '0;
                        plane_q   <= '0;
                        rd_addr_q <= '0;
                        fs_q      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (sub_q == '0) begin
                        sub_q <= SW'(1);
                    end else begin
                        state_q   <= ST_SHIFT;
                        sub_q     <= '0;
                        col_q     <= '0;
                        hub_clk_q <= 1'b0;
                        rgb_q     <= rgb_d;
                        if (HPIXEL_P > 1) rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (sub_q == SW'(2 * CLK_DIV_P - 1)) begin
                        sub_q     <= '0;
                        hub_clk_q <= 1'b0;
                        if (col_q == CW'(HPIXEL_P - 1)) begin
                            state_q    <= ST_LATCH;
                            lat_q      <= 1'b1;
                            hub_addr_q <= row_q;
                        end else begin
                            col_q <= col_q + CW'(1);
                            rgb_q <= rgb_d;
                            // The last column was already addressed; nothing more to fetch.
                            if (int'(col_q) != HPIXEL_P - 2) rd_addr_q <= rd_addr_q + AW'(1);
                        end
                    end else begin
                        sub_q     <= sub_q + SW'(1);
                        hub_clk_q <= (int'(sub_q) + 1 >= CLK_DIV_P);
                    end
                end
                ST_LATCH: begin
                    if (sub_q == SW'(CLK_DIV_P - 1)) begin
                        sub_q <= '0;
                        lat_q <= 1'b0;
`ifdef HUB75_ROW_BLANK_EN
                        state_q <= ST_BLANK;
`else
                        state_q <= ST_DISPLAY;
                        oe_n_q  <= 1'b0;
`endif
                    end else begin
                        sub_q <= sub_q + SW'(1);
                    end
                end
`ifdef HUB75_ROW_BLANK_EN
                ST_BLANK: begin
                    if (sub_q == SW'(BLANK_CYCLES_P - 1)) begin
                        sub_q   <= '0;
                        state_q <= ST_DISPLAY;
                        oe_n_q  <= 1'b0;
                    end else begin
                        sub_q <= sub_q + SW'(1);
                    end
                end
`endif
                ST_DISPLAY: begin
                    if (tmr_done) begin
                        oe_n_q <= 1'b1;
                        sub_q  <= '0;
                        if (!i_en) begin
                            state_q <= ST_IDLE;
                            row_q   <= '0;
                            plane_q <= '0;
                        end else begin
                            state_q <= ST_FETCH;
                            if (plane_q == PW'(BPP_P - 1)) begin
                                plane_q <= '0;
                                if (row_q == RW'(ROWS - 1)) begin
                                    row_q     <= '0;
                                    rd_addr_q <= '0;
                                    fs_q      <= 1'b1;
                                end else begin
                                    row_q     <= row_q + RW'(1);
                                    rd_addr_q <= row_base(row_q + RW'(1));
                                end
                            end else begin
                                plane_q   <= plane_q + PW'(1);
                                rd_addr_q <= row_base(row_q);
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_rd_addr     = rd_addr_q;
    assign o_hub_clk     = hub_clk_q;
    assign o_hub_lat     = lat_q;
    assign o_hub_oe_n    = oe_n_q;
    assign o_hub_addr    = hub_addr_q;
    assign o_hub_rgb     = rgb_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb/tb_hub75_scan_ctrl.sv - directed bench for hub75_scan_ctrl; blank timing expected under HUB75_ROW_BLANK_EN
module tb_hub75_scan_ctrl;
    localparam int H    = 8;
    localparam int V    = 4;
    localparam int SEG  = 2;
    localparam int BPP  = 2;
    localparam int CDIV = 1;
    localparam int LSB  = 4;
    localparam int BLK  = 3;
    localparam int DW   = SEG * 3 * BPP;
`ifdef HUB75_ROW_BLANK_EN
    localparam int BLANK_EXP = BLK;
`else
    localparam int BLANK_EXP = 0;
`endif
    localparam int PERIOD = 100 + 4 * BLANK_EXP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_en = 1'b0;
    logic [4:0]    o_rd_addr;
    logic [DW-1:0] i_rd_data = '0;
    logic          o_hub_clk, o_hub_lat, o_hub_oe_n, o_frame_start;
    logic [0:0]    o_hub_addr;
    logic [5:0]    o_hub_rgb;

    hub75_scan_ctrl #(
        .HPIXEL_P(H), .VPIXEL_P(V), .BPP_P(BPP), .SEGMENTS_P(SEG),
        .CLK_DIV_P(CDIV), .LSB_OE_CYCLES_P(LSB), .BLANK_CYCLES_P(BLK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_en(i_en),
        .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_hub_clk(o_hub_clk), .o_hub_lat(o_hub_lat), .o_hub_oe_n(o_hub_oe_n),
        .o_hub_addr(o_hub_addr), .o_hub_rgb(o_hub_rgb), .o_frame_start(o_frame_start)
    );

    always #5 clk = ~clk;

    // Test-bar colour: 2-bit value per (row, column, segment, channel).
    function automatic logic [1:0] px(input int r, input int c, input int s, input int k);
        return 2'((c * 3 + k + s * 2 + r * 5) % 4);
    endfunction

    function automatic logic [DW-1:0] pix_word(input int a);
        logic [DW-1:0] w;
        w = '0;
        for (int s = 0; s < SEG; s++)
            for (int k = 0; k < 3; k++)
                w[(s*3+k)*BPP +: BPP] = px(a / H, a % H, s, k);
        return w;
    endfunction

    function automatic logic [5:0] exp_rgb(input int r, input int b, input int c);
        logic [5:0] v;
        logic [1:0] p;
        v = '0;
        for (int s = 0; s < SEG; s++)
            for (int k = 0; k < 3; k++) begin
                p = px(r, c, s, k);
                v[s*3+k] = p[b];
            end
        return v;
    endfunction

    always @(posedge clk) i_rd_data <= pix_word(int'(o_rd_addr));

    // Monitor: records pulses, OE-low runs, shift-clock rises and blank gaps.
    int         cyc = 0;
    int         fs_t[$];
    int         oe_runs[$];
    int         oe_addr[$];
    logic [5:0] rise_rgb[$];
    int         lat_rises[$];
    int         lat_addr[$];
    int         gap_runs[$];
    int         overlap = 0;
    int         run = 0, run_addr = 0, gap = 0;
    bit         in_gap = 0;
    logic       prev_clk = 1'b0, prev_lat = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (o_frame_start) fs_t.push_back(cyc);
        if (o_hub_clk && !prev_clk) rise_rgb.push_back(o_hub_rgb);
        if (o_hub_lat && !prev_lat) begin
            lat_rises.push_back(rise_rgb.size());
            lat_addr.push_back(int'(o_hub_addr));
        end
        if (!o_hub_oe_n) begin
            run++;
            run_addr = int'(o_hub_addr);
            if (o_hub_clk || (o_hub_clk != prev_clk) || o_hub_lat) overlap++;
        end else if (run > 0) begin
            oe_runs.push_back(run);
            oe_addr.push_back(run_addr);
            run = 0;
        end
        if (!o_hub_lat && prev_lat) begin
            in_gap = 1;
            gap = 0;
        end
        if (in_gap) begin
            if (o_hub_oe_n) gap++;
            else begin
                gap_runs.push_back(gap);
                in_gap = 0;
            end
        end
        prev_clk = o_hub_clk;
        prev_lat = o_hub_lat;
    end

    task automatic clear_mon();
        fs_t.delete(); oe_runs.delete(); oe_addr.delete(); rise_rgb.delete();
        lat_rises.delete(); lat_addr.delete(); gap_runs.delete();
        overlap = 0; run = 0; in_gap = 0;
    endtask

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_rd_addr"}, o_rd_addr, 0);
        chk({p, "_hub_clk"}, o_hub_clk, 0);
        chk({p, "_hub_lat"}, o_hub_lat, 0);
        chk({p, "_oe_n"}, o_hub_oe_n, 1);
        chk({p, "_hub_addr"}, o_hub_addr, 0);
        chk({p, "_rgb"}, o_hub_rgb, 0);
        chk({p, "_frame_start"}, o_frame_start, 0);
    endtask

    typedef struct {
        int row;
        int plane;
        int oe_len;
        int hub_addr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int k;
        int n;
        vecs[0] = '{0, 0, 4, 0};
        vecs[1] = '{0, 1, 8, 0};
        vecs[2] = '{1, 0, 4, 1};
        vecs[3] = '{1, 1, 8, 1};

        rst_n = 1'b0;
        i_en  = 1'b0;
        tick(3);
        chk_reset("rst");
        rst_n = 1'b1;
        tick(2);
        chk("idle_no_en_oe_n", o_hub_oe_n, 1);
        chk("idle_no_en_fs", o_frame_start, 0);

        // One full run of frames from enable.
        i_en = 1'b1;
        clear_mon();
        tick(1);
        chk("fs_first", o_frame_start, 1);
        chk("fetch_addr_row0", o_rd_addr, 0);
        tick(1);
        chk("fs_one_cycle", o_frame_start, 0);
        tick(2 * PERIOD + 10);
        chk("fs_count", fs_t.size() >= 3, 1);
        if (fs_t.size() >= 3) begin
            chk("fs_period_1", fs_t[1] - fs_t[0], PERIOD);
            chk("fs_period_2", fs_t[2] - fs_t[1], PERIOD);
        end
        chk("rises_frame", rise_rgb.size() >= 32, 1);
        chk("runs_frame", oe_runs.size() >= 4, 1);
        chk("lats_frame", lat_rises.size() >= 4, 1);
        chk("gaps_frame", gap_runs.size() >= 4, 1);
        for (int e = 0; e < 4; e++) begin
            if (oe_runs.size() > e) begin
                chk($sformatf("oe_len_%0d", e), oe_runs[e], vecs[e].oe_len);
                chk($sformatf("oe_addr_%0d", e), oe_addr[e], vecs[e].hub_addr);
            end
            if (lat_rises.size() > e)
                chk($sformatf("lat_after_rises_%0d", e), lat_rises[e], 8 * (e + 1));
            if (gap_runs.size() > e)
                chk($sformatf("blank_gap_%0d", e), gap_runs[e], BLANK_EXP);
            for (int c = 0; c < H; c++) begin
                if (rise_rgb.size() > e * H + c)
                    chk($sformatf("rgb_r%0d_p%0d_c%0d", vecs[e].row, vecs[e].plane, c),
                        rise_rgb[e*H+c], exp_rgb(vecs[e].row, vecs[e].plane, c));
            end
        end
        chk("oe_vs_clk_overlap", overlap, 0);

        // Drop enable while shifting row 1, plane 0.
        rst_n = 1'b0;
        i_en  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        i_en = 1'b1;
        clear_mon();
        for (k = 0; k < 300 && oe_runs.size() < 2; k++) tick(1);
        chk("b_wait_row0_done", oe_runs.size() >= 2, 1);
        for (k = 0; k < 40 && !o_hub_clk; k++) tick(1);
        chk("b_wait_shift_row1", o_hub_clk, 1);
        i_en = 1'b0;
        tick(40);
        chk("b_runs", oe_runs.size(), 3);
        if (oe_runs.size() >= 3) begin
            chk("b_last_len", oe_runs[2], 4);
            chk("b_last_addr", oe_addr[2], 1);
        end
        chk("b_idle_oe_n", o_hub_oe_n, 1);
        chk("b_idle_lat", o_hub_lat, 0);
        n = rise_rgb.size();
        tick(10);
        chk("b_idle_no_shift", rise_rgb.size(), n);
        chk("b_fs_count", fs_t.size(), 1);

        i_en = 1'b1;
        clear_mon();
        for (k = 0; k < 60 && lat_addr.size() < 1; k++) tick(1);
        chk("b_restart_lat_seen", lat_addr.size() >= 1, 1);
        if (lat_addr.size() >= 1) chk("b_restart_hub_addr", lat_addr[0], 0);
        if (rise_rgb.size() >= 1) chk("b_restart_rgb0", rise_rgb[0], exp_rgb(0, 0, 0));
        chk("b_restart_fs", fs_t.size(), 1);

        // Reset for one cycle during row 1 DISPLAY.
        for (k = 0; k < 300 && oe_runs.size() < 2; k++) tick(1);
        for (k = 0; k < 60 && o_hub_oe_n; k++) tick(1);
        chk("c_in_display", o_hub_oe_n, 0);
        chk("c_display_row1", o_hub_addr, 1);
        rst_n = 1'b0;
        i_en  = 1'b0;
        tick(1);
        chk_reset("c_rst");
        rst_n = 1'b1;
        tick(4);
        chk("c_idle_oe_n", o_hub_oe_n, 1);
        chk("c_idle_clk", o_hub_clk, 0);
        chk("c_idle_rd_addr", o_rd_addr, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, tests run %0d", n_run);
        $fatal(1);
    end

endmodule
